// File: rtl/ddr_cmd_sched.sv
// ddr_cmd_sched: MT46H32M16LF command scheduler (power-up init, per-bank row tracking, periodic refresh).
// Define AUTO_PRECHARGE_EN for closed-page operation; otherwise rows stay open until a miss or refresh.
module ddr_cmd_sched #(
   parameter int unsigned INIT_CYCLES  = 200,
   parameter int unsigned T_RP         = 3,
   parameter int unsigned T_RCD        = 3,
   parameter int unsigned T_RFC        = 10,
   parameter int unsigned BURST_GAP    = 2,
   parameter int unsigned REF_INTERVAL = 780,
   parameter logic [12:0] MODE_REG     = 13'h021
) (
   input  logic        DDR_CLK,
   input  logic        RST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WE,
   input  logic [1:0]  REQ_BA,
   input  logic [12:0] REQ_ROW,
   input  logic [9:0]  REQ_COL,
   output logic        REQ_DONE,
   output logic        INIT_DONE,
   output logic        CKE,
   output logic        RAS_N,
   output logic        CAS_N,
   output logic        WE_N,
   output logic [1:0]  BA,
   output logic [12:0] ADDR
);

   localparam int unsigned TMR_W = 16;
   localparam int unsigned BA_W  = 2;
   localparam int unsigned ROW_W = 13;
   localparam int unsigned COL_W = 10;
   localparam int unsigned NBANK = 4;

`ifdef AUTO_PRECHARGE_EN
   localparam logic        AP_BIT = 1'b1;
   localparam int unsigned RW_GAP = BURST_GAP + T_RP;
`else
   localparam logic        AP_BIT = 1'b0;
   localparam int unsigned RW_GAP = BURST_GAP;
`endif

   localparam logic [TMR_W-1:0] INIT_LOAD  = TMR_W'(INIT_CYCLES);
   localparam logic [TMR_W-1:0] TRP_M1     = TMR_W'(T_RP - 1);
   localparam logic [TMR_W-1:0] TRCD_M1    = TMR_W'(T_RCD - 1);
   localparam logic [TMR_W-1:0] TRFC_M1    = TMR_W'(T_RFC - 1);
   localparam logic [TMR_W-1:0] GAP_M1     = TMR_W'(RW_GAP - 1);
   localparam logic [TMR_W-1:0] REF_RELOAD = TMR_W'(REF_INTERVAL - 1);
   localparam logic [ROW_W-1:0] ADDR_ALL   = 13'h400;

   // {RAS_N, CAS_N, WE_N}
   typedef enum logic [2:0] {
      CMD_LMR = 3'b000,
      CMD_REF = 3'b001,
      CMD_PRE = 3'b010,
      CMD_ACT = 3'b011,
      CMD_WR  = 3'b100,
      CMD_RD  = 3'b101,
      CMD_NOP = 3'b111
   } cmd_e;

   typedef enum logic [3:0] {
      S_INIT_WAIT,
      S_INIT_PRE,
      S_INIT_REF1,
      S_INIT_REF2,
      S_INIT_LMR,
      S_INIT_FIN,
      S_IDLE,
      S_DECODE,
      S_ACT,
      S_RW,
      S_REF,
      S_GAP
   } state_e;

   state_e                       state_q, state_d;
   logic [TMR_W-1:0]             timer_q, timer_d;
   cmd_e                         cmd_q, cmd_d;
   logic [BA_W-1:0]              ba_q, ba_d;
   logic [ROW_W-1:0]             addr_q, addr_d;
   logic                         cke_q, cke_d;
   logic                         init_done_q, init_done_d;
   logic                         req_ready_q, req_ready_d;
   logic                         req_done_q, req_done_d;
   logic [NBANK-1:0]             open_q, open_d;
   logic [NBANK-1:0][ROW_W-1:0]  row_q, row_d;
   logic                         req_we_q, req_we_d;
   logic [BA_W-1:0]              req_ba_q, req_ba_d;
   logic [ROW_W-1:0]             req_row_q, req_row_d;
   logic [COL_W-1:0]             req_col_q, req_col_d;
   logic [TMR_W-1:0]             ref_cnt_q, ref_cnt_d;
   logic                         ref_pend_q, ref_pend_d;

   logic                         tmr_zero;
   logic                         act_go;
   logic                         rw_go;
   logic                         ref_go;

   // Next-state, command selection and bookkeeping
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      cmd_d       = CMD_NOP;
      ba_d        = ba_q;
      addr_d      = addr_q;
      cke_d       = cke_q;
      init_done_d = init_done_q;
      req_done_d  = 1'b0;
      open_d      = open_q;
      row_d       = row_q;
      req_we_d    = req_we_q;
      req_ba_d    = req_ba_q;
      req_row_d   = req_row_q;
      req_col_d   = req_col_q;
      ref_cnt_d   = ref_cnt_q;
      ref_pend_d  = ref_pend_q;
      act_go      = 1'b0;
      rw_go       = 1'b0;
      ref_go      = 1'b0;

      tmr_zero = (timer_q == '0);
      if (!tmr_zero) begin
         timer_d = timer_q - TMR_W'(1);
      end

      case (state_q)
         S_INIT_WAIT: begin
            if (tmr_zero) begin
               cke_d   = 1'b1;
               state_d = S_INIT_PRE;
            end
         end
         S_INIT_PRE: begin
            cmd_d   = CMD_PRE;
            ba_d    = '0;
            addr_d  = ADDR_ALL;
            timer_d = TRP_M1;
            state_d = S_INIT_REF1;
         end
         S_INIT_REF1: begin
            if (tmr_zero) begin
               cmd_d   = CMD_REF;
               timer_d = TRFC_M1;
               state_d = S_INIT_REF2;
            end
         end
         S_INIT_REF2: begin
            if (tmr_zero) begin
               cmd_d   = CMD_REF;
               timer_d = TRFC_M1;
               state_d = S_INIT_LMR;
            end
         end
         S_INIT_LMR: begin
            if (tmr_zero) begin
               cmd_d   = CMD_LMR;
               ba_d    = '0;
               addr_d  = MODE_REG;
               state_d = S_INIT_FIN;
            end
         end
         S_INIT_FIN: begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
         end
         S_IDLE: begin
            // A pending refresh always beats a waiting request
            if (ref_pend_q) begin
               if (|open_q) begin
                  cmd_d   = CMD_PRE;
                  ba_d    = '0;
                  addr_d  = ADDR_ALL;
                  timer_d = TRP_M1;
                  state_d = S_REF;
               end else begin
                  ref_go = 1'b1;
               end
            end else if (REQ_VALID && req_ready_q) begin
               req_we_d  = REQ_WE;
               req_ba_d  = REQ_BA;
               req_row_d = REQ_ROW;
               req_col_d = REQ_COL;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!open_q[req_ba_q]) begin
               act_go = 1'b1;
            end else if (row_q[req_ba_q] == req_row_q) begin
               rw_go = 1'b1;
            end else begin
               cmd_d   = CMD_PRE;
               ba_d    = req_ba_q;
               addr_d  = '0;
               timer_d = TRP_M1;
               state_d = S_ACT;
            end
         end
         S_ACT: begin
            if (tmr_zero) act_go = 1'b1;
         end
         S_RW: begin
            if (tmr_zero) rw_go = 1'b1;
         end
         S_REF: begin
            if (tmr_zero) ref_go = 1'b1;
         end
         S_GAP: begin
            if (tmr_zero) state_d = S_IDLE;
         end
         default: begin
            state_d = S_INIT_WAIT;
         end
      endcase

      if (act_go) begin
         cmd_d            = CMD_ACT;
         ba_d             = req_ba_q;
         addr_d           = req_row_q;
         open_d[req_ba_q] = 1'b1;
         row_d[req_ba_q]  = req_row_q;
         timer_d          = TRCD_M1;
         state_d          = S_RW;
      end

      if (rw_go) begin
         cmd_d      = req_we_q ? CMD_WR : CMD_RD;
         ba_d       = req_ba_q;
         addr_d     = {2'b00, AP_BIT, req_col_q};
         req_done_d = 1'b1;
         timer_d    = GAP_M1;
         state_d    = S_GAP;
`ifdef AUTO_PRECHARGE_EN
         open_d[req_ba_q] = 1'b0;
`endif
      end

      if (ref_go) begin
         cmd_d      = CMD_REF;
         open_d     = '0;
         ref_pend_d = 1'b0;
         timer_d    = TRFC_M1;
         state_d    = S_GAP;
      end

      // Refresh interval timer; an expiry while one is already pending is dropped
      if (init_done_q) begin
         if (ref_cnt_q == '0) begin
            ref_pend_d = 1'b1;
            ref_cnt_d  = REF_RELOAD;
         end else begin
            ref_cnt_d = ref_cnt_q - TMR_W'(1);
         end
      end

      req_ready_d = (state_d == S_IDLE) && !ref_pend_d;
   end

   always_ff @(posedge DDR_CLK) begin
      if (RST) begin
         state_q     <= S_INIT_WAIT;
         timer_q     <= INIT_LOAD;
         cmd_q       <= CMD_NOP;
         ba_q        <= '0;
         addr_q      <= '0;
         cke_q       <= 1'b0;
         init_done_q <= 1'b0;
         req_ready_q <= 1'b0;
         req_done_q  <= 1'b0;
         open_q      <= '0;
         row_q       <= '0;
         req_we_q    <= 1'b0;
         req_ba_q    <= '0;
         req_row_q   <= '0;
         req_col_q   <= '0;
         ref_cnt_q   <= REF_RELOAD;
         ref_pend_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         cmd_q       <= cmd_d;
         ba_q        <= ba_d;
         addr_q      <= addr_d;
         cke_q       <= cke_d;
         init_done_q <= init_done_d;
         req_ready_q <= req_ready_d;
         req_done_q  <= req_done_d;
         open_q      <= open_d;
         row_q       <= row_d;
         req_we_q    <= req_we_d;
         req_ba_q    <= req_ba_d;
         req_row_q   <= req_row_d;
         req_col_q   <= req_col_d;
         ref_cnt_q   <= ref_cnt_d;
         ref_pend_q  <= ref_pend_d;
      end
   end

   assign {RAS_N, CAS_N, WE_N} = cmd_q;
   assign BA        = ba_q;
   assign ADDR      = addr_q;
   assign CKE       = cke_q;
   assign INIT_DONE = init_done_q;
   assign REQ_READY = req_ready_q;
   assign REQ_DONE  = req_done_q;

endmodule
